aes128_round_sched: RTL and testbench

- Iterative AES-128 encryption sequencer.
- Accepts one 128-bit plaintext block and runs the initial AddRoundKey.
- Then time-multiplexes a single external combinational round datapath over NR rounds. The datapath is SubBytes, ShiftRows, then the MixColumns+AddRoundKey stage.
- Round keys are fetched by index from an external combinational key store. The block owns the state register, round counter, last-round flag and valid/ready handshakes.

---
 rtl/aes128_round_sched.sv | 99 +++++++++
 tb/tb_aes128_round_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_round_sched.sv
// Iterative AES-128 encryption sequencer.
// Performs the initial AddRoundKey on accept, then steps an external
// combinational round datapath through NR rounds, fetching round keys by
// index from an external combinational key store. Output is held until the
// consumer takes it. A new block can be accepted on the same edge that
// consumes the previous result.
module aes128_round_sched #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  localparam logic [3:0] NR_LAST = 4'(NR);

  state_t       fsm;
  logic [127:0] st;
  logic         accept;

  // Handshakes, key index and datapath drive derived from registered state;
  // only in_ready (via out_ready) and dp_key (via rk_data) are combinational.
  always_comb begin
    in_ready  = !rst && ((fsm == IDLE) || ((fsm == DONE) && out_ready));
    accept    = in_valid && in_ready;
    rk_idx    = (fsm == ROUND) ? round : '0;
    dp_state  = st;
    dp_key    = rk_data;
    dp_last   = (fsm == ROUND) && (round == NR_LAST);
    out_valid = (fsm == DONE);
    out_data  = st;
    busy      = (fsm == ROUND);
  end

  // Sequencer: load with initial key add, iterate rounds, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm   <= IDLE;
      round <= '0;
      st    <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            st    <= in_data ^ rk_data;
            round <= 4'd1;
            fsm   <= ROUND;
          end
        end
        ROUND: begin
          st <= dp_result;
          if (round == NR_LAST) begin
            fsm <= DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        DONE: begin
          // Consuming the result and accepting the next block can coincide,
          // giving back-to-back blocks with no idle cycle in between.
          if (out_ready) begin
            if (accept) begin
              st    <= in_data ^ rk_data;
              round <= 4'd1;
              fsm   <= ROUND;
            end else begin
              round <= '0;
              fsm   <= IDLE;
            end
          end
        end
        default: begin
          fsm   <= IDLE;
          round <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_round_sched.sv
// Self-checking bench for aes128_round_sched: a reference AES round datapath
// and key-expansion store surround two instances (NR=10 and NR=1).
module tb_aes128_round_sched;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] RK1_C1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] R1_START_C1 = 128'h00102030405060708090a0b0c0d0e0f0;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  int   ksel;
  logic [1407:0] rk_all [3];

  logic         in_valid_a, in_ready_a, dp_last_a, out_valid_a, out_ready_a, busy_a;
  logic [127:0] in_data_a, rk_data_a, dp_state_a, dp_key_a, dp_result_a, out_data_a;
  logic [3:0]   rk_idx_a, round_a;

  logic         in_valid_b, in_ready_b, dp_last_b, out_valid_b, out_ready_b, busy_b;
  logic [127:0] in_data_b, rk_data_b, dp_state_b, dp_key_b, dp_result_b, out_data_b;
  logic [3:0]   rk_idx_b, round_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  aes128_round_sched #(.NR(10)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .rk_idx(rk_idx_a), .rk_data(rk_data_a),
    .dp_state(dp_state_a), .dp_key(dp_key_a), .dp_last(dp_last_a),
    .dp_result(dp_result_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .busy(busy_a), .round(round_a)
  );

  aes128_round_sched #(.NR(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .rk_idx(rk_idx_b), .rk_data(rk_data_b),
    .dp_state(dp_state_b), .dp_key(dp_key_b), .dp_last(dp_last_b),
    .dp_result(dp_result_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .busy(busy_b), .round(round_b)
  );

  // ---------------- reference AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0]  inv = 8'h01;
    logic [7:0]  base = x;
    int unsigned e = 254;
    while (e != 0) begin
      if (e[0]) inv = gmul(inv, base);
      base = gmul(base, base);
      e = e >> 1;
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o ^ k;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   tmp;
    logic [7:0]    rc = 8'h01;
    logic [1407:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
    return o;
  endfunction

  // ---------------- external key stores and datapaths ----------------
  always_comb begin
    rk_data_a = '0;
    if (rk_idx_a <= 4'd10) rk_data_a = rk_all[ksel][1407-128*int'(rk_idx_a) -: 128];
  end
  always_comb begin
    rk_data_b = '0;
    if (rk_idx_b <= 4'd10) rk_data_b = rk_all[0][1407-128*int'(rk_idx_b) -: 128];
  end
  always_comb dp_result_a = aes_round(dp_state_a, dp_key_a, dp_last_a);
  always_comb dp_result_b = aes_round(dp_state_b, dp_key_b, dp_last_b);

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one block on dut_a (inputs already driven) and follow it to DONE.
  task automatic run_a(input logic [127:0] exp_ct, input bit drop, output int t_acc);
    int edges;
    int nb;
    nb = 0;
    chk("accept_in_ready", in_ready_a, 1);
    chk("accept_rk_idx", rk_idx_a, 0);
    t_acc = cyc_cnt;
    tick();
    if (drop) in_valid_a = 1'b0;
    edges = 1;
    while (!out_valid_a && edges < 40) begin
      chk("round_busy", busy_a, 1);
      chk("round_rk_idx", rk_idx_a, 128'(edges));
      chk("round_dp_last", dp_last_a, edges == 10);
      chk("round_in_ready", in_ready_a, 0);
      nb++;
      tick();
      edges++;
    end
    chk("busy_cycles", 128'(nb), 10);
    chk("latency_edges", 128'(edges), 11);
    chk("done_out_valid", out_valid_a, 1);
    chk("done_round", round_a, 10);
    chk("ciphertext", out_data_a, exp_ct);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, tx;
    logic [127:0] exp_b;
    rst = 1'b1; ksel = 0;
    in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
    rk_all[0] = expand(K_C1);
    rk_all[1] = expand(K_B);
    rk_all[2] = expand(128'h0);

    // Reset state
    tick(); tick();
    chk("rst_in_ready_a", in_ready_a, 0);
    chk("rst_in_ready_b", in_ready_b, 0);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_dp_last", dp_last_a, 0);
    chk("rst_rk_idx", rk_idx_a, 0);
    chk("rst_round", round_a, 0);
    chk("rst_dp_state", dp_state_a, 0);
    chk("rst_dp_key", dp_key_a, K_C1);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready_a, 1);

    // FIPS-197 C.1 with index / dp_last sequencing
    in_data_a = PT_C1; in_valid_a = 1'b1;
    #1;
    run_a(CT_C1, 1, tx);
    tick();
    chk("consume_out_valid", out_valid_a, 0);
    chk("consume_round", round_a, 0);
    chk("consume_in_ready", in_ready_a, 1);

    // Backpressure with in_valid held high
    ksel = 1; in_data_a = PT_B; in_valid_a = 1'b1; out_ready_a = 1'b0;
    #1;
    run_a(CT_B, 0, tx);
    ksel = 2; in_data_a = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", in_ready_a, 0);
      chk("bp_out_valid", out_valid_a, 1);
      chk("bp_out_data", out_data_a, CT_B);
      tick();
    end
    out_ready_a = 1'b1;
    #1;
    run_a(CT_Z, 1, tx);
    tick();

    // Back-to-back stream of three vectors
    ksel = 0; in_data_a = PT_C1; in_valid_a = 1'b1; out_ready_a = 1'b1;
    #1;
    run_a(CT_C1, 0, t0);
    ksel = 1; in_data_a = PT_B;
    #1;
    run_a(CT_B, 0, t1);
    ksel = 2; in_data_a = '0;
    #1;
    run_a(CT_Z, 1, t2);
    chk("b2b_gap_1", 128'(t1 - t0), 11);
    chk("b2b_gap_2", 128'(t2 - t1), 11);
    tick();

    // Reset in the middle of round 5
    ksel = 0; in_data_a = PT_C1; in_valid_a = 1'b1;
    #1;
    chk("midrst_accept", in_ready_a, 1);
    tick();
    in_valid_a = 1'b0;
    repeat (4) tick();
    chk("midrst_round5", round_a, 5);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready_in_rst", in_ready_a, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_round", round_a, 0);
    chk("midrst_out_data", out_data_a, 0);
    chk("midrst_in_ready", in_ready_a, 1);
    in_valid_a = 1'b1;
    #1;
    run_a(CT_C1, 1, tx);
    tick();

    // NR=1 instance
    exp_b = aes_round(PT_C1 ^ K_C1, RK1_C1, 1'b1);
    in_data_b = PT_C1; in_valid_b = 1'b1;
    #1;
    chk("nr1_in_ready", in_ready_b, 1);
    chk("nr1_rk_idx0", rk_idx_b, 0);
    tick();
    in_valid_b = 1'b0;
    #1;
    chk("nr1_busy", busy_b, 1);
    chk("nr1_rk_idx1", rk_idx_b, 1);
    chk("nr1_dp_last", dp_last_b, 1);
    chk("nr1_dp_state", dp_state_b, R1_START_C1);
    chk("nr1_dp_key", dp_key_b, RK1_C1);
    chk("nr1_out_valid_early", out_valid_b, 0);
    tick();
    chk("nr1_out_valid", out_valid_b, 1);
    chk("nr1_dp_last_done", dp_last_b, 0);
    chk("nr1_busy_done", busy_b, 0);
    chk("nr1_round", round_b, 1);
    chk("nr1_ciphertext", out_data_b, exp_b);
    tick();
    chk("nr1_consumed", out_valid_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
